ysyx_25040101_ifu_pc: RTL and testbench
=======================================

// Module: ysyx_25040101_ifu_pc
// PURPOSE
//  Architectural PC register and single-outstanding instruction-fetch engine.
//  Consumes the next PC from the pc_plus adder, holds it and issues a fetch request.
//  Delivers the fetched instruction and its PC to decode.
//  Sits between pc_plus (upstream PC source) and the fetch bus / IDU.
//  Non-pipelined: exactly one instruction in flight.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  DATA_LEN   32             width of PC, address and instruction
// PORTS
//  clk                 in   1   single clock, rising edge
//  rst_n               in   1   reset, asynchronous, active-low
//  raw_next_pc_i       in   32  next PC from pc_plus
//  next_pc_valid_i     in   1   next PC is final (instruction retired)
//  next_pc_ready_o     out  1   block accepts raw_next_pc_i this cycle
//  ifetch_req_valid_o  out  1   fetch request valid
//  ifetch_req_ready_i  in   1   bus accepts request
//  ifetch_addr_o       out  32  fetch address (= pc_o)
//  ifetch_rsp_valid_i  in   1   fetch response valid
//  ifetch_rsp_data_i   in   32  fetched instruction
//  ifetch_rsp_err_i    in   1   bus error, qualified by rsp_valid
//  inst_valid_o        out  1   instruction available to IDU
//  inst_ready_i        in   1   IDU accepts instruction
//  inst_o              out  32  latched instruction
//  inst_pc_o           out  32  PC of inst_o
//  pc_o                out  32  current architectural PC
//  fetch_fault_o       out  1   sticky fault (misaligned PC or bus error)
//  fetch_cnt_o         out  32  count of instructions delivered to IDU
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC; state=REQ; inst_o=0; inst_pc_o=0;
//    fetch_cnt_o=0; fetch_fault_o=0; all valid/ready outputs 0 while rst_n=0.
//  All outputs are decoded from registered state/pc only; no input->output comb path.
//  FSM states:
//   REQ   : req_valid=1, addr=pc. On req_ready -> WAIT. If pc[1:0]!=0 -> FAULT; no request issued.
//   WAIT  : await rsp_valid. If err=1 -> FAULT. Else latch inst_o=rsp_data, inst_pc_o=pc -> DLVR.
//   DLVR  : inst_valid=1. On inst_ready: fetch_cnt+=1 (wraps 2^32-1 -> 0) -> NPC.
//   NPC   : next_pc_ready=1. On next_pc_valid: pc<=raw_next_pc_i -> REQ.
//   FAULT : fetch_fault_o=1. All valids/readys 0. Exit only via reset.
//  Latency:
//   - rst_n release -> req_valid high on the first clk edge.
//   - rsp_valid -> inst_valid on the next cycle.
//   - next_pc handshake -> req_valid on the next cycle.
//  Handshakes are valid/ready: a transfer occurs on the edge where both are high.
//   - req_valid, addr, inst_valid, inst_o and inst_pc_o stay stable until the handshake completes.
//  Out-of-state inputs are ignored and change no state:
//   - rsp_valid outside WAIT (including in the same cycle as the req handshake).
//   - next_pc_valid outside NPC.
//   - inst_ready outside DLVR.
//  ifetch_rsp_data_i is ignored when err=1; inst_o keeps its previous value.
//  PC wrap: raw_next_pc_i taken verbatim (0xFFFF_FFFC+4 = 0 is legal).
//  Misalignment is checked in REQ, so a bad JALR target faults before any bus access.
//  Reset asserted mid-operation: state/pc reinitialise immediately.
//   - Any in-flight bus response is ignored after release, since the FSM restarts in REQ.
// STRUCTURE
//  Shared defines package holds RESET_PC default and DATA_LEN.
//  Local 3-bit state encoding: REQ=0, WAIT=1, DLVR=2, NPC=3, FAULT=4.
//  Unused encodings 5-7 recover to FAULT.
//  Single module; no sub-module needed.
//  Output select for req/inst valids uses the existing generic mux.
// TESTING
//  1 Release reset, ready=1 -> addr=0x8000_0000 cycle 1; rsp 0x00000013 -> inst_o=0x13, inst_pc_o=0x8000_0000.
//  2 IDU stall: inst_ready=0 for 5 cycles -> inst_valid/inst_o stable; fetch_cnt increments once on accept.
//  3 next_pc_valid with raw_next_pc_i=0x8000_0102 -> no request issued, fetch_fault_o=1, stays high.
//  4 rsp_valid=1, err=1 in WAIT -> FAULT, inst_valid never rises; spurious rsp_valid in NPC ignored.
//  5 Bus ready=0 for 3 cycles then 1 -> single request, addr held; next pc 0x8000_0004 fetched after.
//  6 rst_n low during WAIT -> pc=0x8000_0000, cnt=0; late rsp after release ignored, new request issued.

Source files
------------

// File: rtl/ysyx_25040101_ifu_pc_pkg.sv
// Shared definitions for the IFU PC / fetch engine: widths, reset PC,
// FSM state encoding and the generic valid-select mux.
package ysyx_25040101_ifu_pc_pkg;

  localparam int DATA_LEN = 32;
  localparam logic [DATA_LEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  // Encodings 5..7 are unused and recover to ST_FAULT.
  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DLVR  = 3'd2,
    ST_NPC   = 3'd3,
    ST_FAULT = 3'd4
  } ifu_state_e;

  // Generic 2:1 select used for the valid outputs: sel=1 picks b.
  function automatic logic vmux(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/ysyx_25040101_ifu_pc_if.sv
// Bundle of the next-PC, fetch-bus and IDU handshakes of the IFU PC block.
// Every handshake is valid/ready: a transfer happens on the rising clock edge
// where both valid and ready are high; the valid side holds its payload stable
// until that edge.
// The master modport is the IFU itself; slave is the surrounding system.
interface ysyx_25040101_ifu_pc_if;
  import ysyx_25040101_ifu_pc_pkg::*;

  logic [DATA_LEN-1:0] raw_next_pc_i;
  logic                next_pc_valid_i;
  logic                next_pc_ready_o;
  logic                ifetch_req_valid_o;
  logic                ifetch_req_ready_i;
  logic [DATA_LEN-1:0] ifetch_addr_o;
  logic                ifetch_rsp_valid_i;
  logic [DATA_LEN-1:0] ifetch_rsp_data_i;
  logic                ifetch_rsp_err_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [DATA_LEN-1:0] inst_o;
  logic [DATA_LEN-1:0] inst_pc_o;
  logic [DATA_LEN-1:0] pc_o;
  logic                fetch_fault_o;
  logic [DATA_LEN-1:0] fetch_cnt_o;
  ifu_state_e          state_dbg_o;

  modport master (
    input  raw_next_pc_i, next_pc_valid_i, ifetch_req_ready_i,
    input  ifetch_rsp_valid_i, ifetch_rsp_data_i, ifetch_rsp_err_i, inst_ready_i,
    output next_pc_ready_o, ifetch_req_valid_o, ifetch_addr_o, inst_valid_o,
    output inst_o, inst_pc_o, pc_o, fetch_fault_o, fetch_cnt_o, state_dbg_o
  );

  modport slave (
    output raw_next_pc_i, next_pc_valid_i, ifetch_req_ready_i,
    output ifetch_rsp_valid_i, ifetch_rsp_data_i, ifetch_rsp_err_i, inst_ready_i,
    input  next_pc_ready_o, ifetch_req_valid_o, ifetch_addr_o, inst_valid_o,
    input  inst_o, inst_pc_o, pc_o, fetch_fault_o, fetch_cnt_o, state_dbg_o
  );

endinterface

// File: rtl/ysyx_25040101_ifu_pc.sv
// Architectural PC register and single-outstanding instruction fetch engine.
// Cycle: REQ (issue fetch) -> WAIT (response) -> DLVR (hand to IDU) ->
// NPC (take next PC) -> REQ. Misaligned PC or bus error parks in FAULT until
// reset. All outputs are decoded from registers only.
module ysyx_25040101_ifu_pc
  import ysyx_25040101_ifu_pc_pkg::*;
#(
  parameter logic [DATA_LEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25040101_ifu_pc_if.master    bus
);

  ifu_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic [DATA_LEN-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_LEN-1:0] cnt_q, cnt_d;
  // Low during reset and for no longer: keeps every valid/ready at 0 while
  // rst_n is asserted without a combinational path from rst_n to outputs.
  logic                run_q;
  logic                pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  // State, PC and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
    end
  end

  // Next-state and datapath updates; inputs are only looked at in the state
  // that owns them, so out-of-state strobes change nothing.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_REQ: begin
        if (run_q) begin
          if (!pc_aligned)                 state_d = ST_FAULT;
          else if (bus.ifetch_req_ready_i) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ifetch_rsp_valid_i) begin
          if (bus.ifetch_rsp_err_i) begin
            state_d = ST_FAULT;
          end else begin
            inst_d    = bus.ifetch_rsp_data_i;
            inst_pc_d = pc_q;
            state_d   = ST_DLVR;
          end
        end
      end
      ST_DLVR: begin
        if (bus.inst_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_NPC;
        end
      end
      ST_NPC: begin
        if (bus.next_pc_valid_i) begin
          pc_d    = bus.raw_next_pc_i;
          state_d = ST_REQ;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Output decode from registered state and PC.
  always_comb begin
    bus.ifetch_req_valid_o = vmux(state_q == ST_REQ, 1'b0, run_q & pc_aligned);
    bus.inst_valid_o       = vmux(state_q == ST_DLVR, 1'b0, run_q);
    bus.next_pc_ready_o    = (state_q == ST_NPC);
    bus.fetch_fault_o      = (state_q == ST_FAULT);
    bus.ifetch_addr_o      = pc_q;
    bus.pc_o               = pc_q;
    bus.inst_o             = inst_q;
    bus.inst_pc_o          = inst_pc_q;
    bus.fetch_cnt_o        = cnt_q;
    bus.state_dbg_o        = state_q;
  end

endmodule

// File: tb/tb_ysyx_25040101_ifu_pc.sv
// Bench for the IFU PC block: directed scenarios plus a randomized fetch loop,
// checked against a transaction-level model of the architectural state.
module tb_ysyx_25040101_ifu_pc;
  import ysyx_25040101_ifu_pc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_25040101_ifu_pc_if bus();

  ysyx_25040101_ifu_pc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- model / scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] m_pc, m_cnt, m_inst, m_inst_pc;
  logic        m_fault;
  logic [31:0] exp_q[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.raw_next_pc_i      = '0;
    bus.next_pc_valid_i    = 1'b0;
    bus.ifetch_req_ready_i = 1'b0;
    bus.ifetch_rsp_valid_i = 1'b0;
    bus.ifetch_rsp_data_i  = '0;
    bus.ifetch_rsp_err_i   = 1'b0;
    bus.inst_ready_i       = 1'b0;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, ".pc"},      bus.pc_o,                 m_pc);
    chk({tag, ".cnt"},     bus.fetch_cnt_o,          m_cnt);
    chk({tag, ".fault"},   {31'd0, bus.fetch_fault_o}, {31'd0, m_fault});
    chk({tag, ".inst"},    bus.inst_o,               m_inst);
    chk({tag, ".inst_pc"}, bus.inst_pc_o,            m_inst_pc);
  endtask

  task automatic chk_vld(input string tag, input bit req, input bit iv, input bit npr);
    chk({tag, ".req_valid"},  {31'd0, bus.ifetch_req_valid_o}, {31'd0, req});
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid_o},       {31'd0, iv});
    chk({tag, ".npc_ready"},  {31'd0, bus.next_pc_ready_o},    {31'd0, npr});
    chk({tag, ".addr"},       bus.ifetch_addr_o,               m_pc);
  endtask

  // Assert reset, check reset values, release; optionally keep a stale
  // response strobe high across the release.
  task automatic reset_release(input bit late_rsp);
    rst_n = 1'b0;
    idle_inputs();
    bus.ifetch_rsp_valid_i = late_rsp;
    bus.ifetch_rsp_data_i  = 32'hDEAD_BEEF;
    m_pc = RESET_PC_DEF; m_cnt = '0; m_fault = 1'b0; m_inst = '0; m_inst_pc = '0;
    exp_q.delete();
    repeat (2) step();
    chk_arch("rst");
    chk_vld("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_vld("release", 1'b1, 1'b0, 1'b0);
    chk_arch("release");
    if (late_rsp) begin
      step();
      chk_vld("late_rsp", 1'b1, 1'b0, 1'b0);
      chk_arch("late_rsp");
    end
    idle_inputs();
  endtask

  // One full instruction transaction starting in the request phase.
  task automatic fetch(input logic [31:0] data, input bit err, input int bstall,
                       input int istall, input logic [31:0] nxt);
    for (int i = 0; i < bstall; i++) begin
      bus.ifetch_req_ready_i = 1'b0;
      bus.ifetch_rsp_valid_i = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_data_i  = $urandom;
      step();
      chk_vld("req_hold", 1'b1, 1'b0, 1'b0);
      chk_arch("req_hold");
    end
    bus.ifetch_req_ready_i = 1'b1;
    bus.ifetch_rsp_valid_i = 1'($urandom_range(0, 1));
    bus.ifetch_rsp_data_i  = $urandom;
    step();
    idle_inputs();
    chk_vld("wait", 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(0, 2)) begin
      bus.next_pc_valid_i = 1'($urandom_range(0, 1));
      bus.raw_next_pc_i   = $urandom;
      bus.inst_ready_i    = 1'($urandom_range(0, 1));
      step();
      chk_vld("wait_idle", 1'b0, 1'b0, 1'b0);
      chk_arch("wait_idle");
    end
    idle_inputs();
    bus.ifetch_rsp_valid_i = 1'b1;
    bus.ifetch_rsp_data_i  = data;
    bus.ifetch_rsp_err_i   = err;
    if (!err) exp_q.push_back(data);
    step();
    idle_inputs();
    if (err) begin
      m_fault = 1'b1;
      chk_vld("bus_err", 1'b0, 1'b0, 1'b0);
      chk_arch("bus_err");
      return;
    end
    m_inst    = exp_q.pop_front();
    m_inst_pc = m_pc;
    chk_vld("dlvr", 1'b0, 1'b1, 1'b0);
    chk_arch("dlvr");
    for (int i = 0; i < istall; i++) begin
      bus.next_pc_valid_i    = 1'($urandom_range(0, 1));
      bus.raw_next_pc_i      = $urandom;
      bus.ifetch_rsp_valid_i = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_data_i  = $urandom;
      step();
      chk_vld("dlvr_hold", 1'b0, 1'b1, 1'b0);
      chk_arch("dlvr_hold");
    end
    idle_inputs();
    bus.inst_ready_i = 1'b1;
    step();
    idle_inputs();
    m_cnt = m_cnt + 32'd1;
    chk_vld("npc", 1'b0, 1'b0, 1'b1);
    chk_arch("npc");
    repeat ($urandom_range(0, 2)) begin
      bus.inst_ready_i       = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_valid_i = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_data_i  = $urandom;
      bus.raw_next_pc_i      = $urandom;
      step();
      chk_vld("npc_idle", 1'b0, 1'b0, 1'b1);
      chk_arch("npc_idle");
    end
    idle_inputs();
    bus.next_pc_valid_i = 1'b1;
    bus.raw_next_pc_i   = nxt;
    step();
    idle_inputs();
    m_pc = nxt;
    if (nxt[1:0] == 2'b00) begin
      chk_vld("next_req", 1'b1, 1'b0, 1'b0);
      chk_arch("next_req");
    end else begin
      chk_vld("misalign_req", 1'b0, 1'b0, 1'b0);
      chk_arch("misalign_req");
      step();
      m_fault = 1'b1;
      chk_vld("misalign_fault", 1'b0, 1'b0, 1'b0);
      chk_arch("misalign_fault");
    end
  endtask

  // Hammer every input while parked in FAULT; nothing may move.
  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) begin
      bus.raw_next_pc_i      = $urandom;
      bus.next_pc_valid_i    = 1'($urandom_range(0, 1));
      bus.ifetch_req_ready_i = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_valid_i = 1'($urandom_range(0, 1));
      bus.ifetch_rsp_data_i  = $urandom;
      bus.ifetch_rsp_err_i   = 1'($urandom_range(0, 1));
      bus.inst_ready_i       = 1'($urandom_range(0, 1));
      step();
      chk_vld("fault_hold", 1'b0, 1'b0, 1'b0);
      chk_arch("fault_hold");
    end
    idle_inputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] nxt;
    rst_n = 1'b0;
    idle_inputs();

    // Reset, then first fetch of a NOP at the reset PC.
    reset_release(1'b0);
    fetch(32'h0000_0013, 1'b0, 0, 0, 32'h8000_0004);

    // IDU stalls five cycles.
    fetch($urandom, 1'b0, 0, 5, m_pc + 32'd4);

    // Bus stalls three cycles, then jump back to 0x8000_0004.
    fetch($urandom, 1'b0, 3, 0, 32'h8000_0004);
    fetch($urandom, 1'b0, 0, 0, m_pc + 32'd4);

    // PC wrap: 0xFFFF_FFFC followed by 0.
    fetch($urandom, 1'b0, 1, 1, 32'hFFFF_FFFC);
    fetch($urandom, 1'b0, 0, 0, m_pc + 32'd4);
    chk("pc_wrap", bus.pc_o, 32'h0000_0000);

    // Randomized stream of well-formed fetches.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) nxt = m_pc + 32'd4;
      else nxt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      fetch($urandom, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), nxt);
    end

    // Misaligned next PC faults without a bus request, and sticks.
    fetch($urandom, 1'b0, 0, 0, 32'h8000_0102);
    fault_hold(6);

    // Bus error in WAIT faults; instruction never delivered.
    reset_release(1'b0);
    fetch(32'h1234_5678, 1'b0, 0, 0, 32'h8000_0004);
    fetch(32'hBAD0_BAD0, 1'b1, 1, 0, 32'h0);
    fault_hold(6);

    // Reset during WAIT, with a stale response still arriving after release.
    reset_release(1'b0);
    fetch($urandom, 1'b0, 0, 1, 32'h8000_0040);
    bus.ifetch_req_ready_i = 1'b1;
    step();
    idle_inputs();
    chk_vld("pre_reset_wait", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc",  bus.pc_o,        RESET_PC_DEF);
    chk("async_rst.cnt", bus.fetch_cnt_o, 32'd0);
    reset_release(1'b1);
    fetch($urandom, 1'b0, 0, 0, m_pc + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
